// File: rtl/axil_pkg.sv
// Shared constants and helpers for the AXI4-Lite register slave.
// The strobe merge helper is used only when AXIL_REG_SLAVE_WSTRB_EN is defined.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ADDR_LSB    = 2;

  // Byte-wise merge: byte b comes from new_word when strb[b] is set, else from old_word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_wr_join.sv
// AW/W holding registers and join: captures each half independently and emits a
// single-cycle commit strobe with the joined address, data and strobe.
module axil_wr_join
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic                  resp_busy_i,
  output logic                  commit_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           data_o,
  output logic [3:0]            strb_o
);

  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic                  aw_hs, w_hs, aw_avail, w_avail;

  assign awready_o = !aw_held_q && !resp_busy_i;
  assign wready_o  = !w_held_q && !resp_busy_i;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  assign aw_avail  = aw_held_q || aw_hs;
  assign w_avail   = w_held_q || w_hs;
  assign commit_o  = aw_avail && w_avail;

  // A half arriving on the commit edge bypasses its holding register.
  assign addr_o = aw_held_q ? aw_addr_q : awaddr_i;
  assign data_o = w_held_q ? w_data_q : wdata_i;
  assign strb_o = w_held_q ? w_strb_q : wstrb_i;

  always_comb begin
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_held_d = commit_o ? 1'b0 : aw_avail;
    w_held_d  = commit_o ? 1'b0 : w_avail;
    if (aw_hs) aw_addr_d = awaddr_i;
    if (w_hs) begin
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file with a read-only status word at offset NUM_REGS.
// Optional byte-strobe support is enabled by defining AXIL_REG_SLAVE_WSTRB_EN.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o,
  input  logic [31:0]              status_i
);

  localparam int              WA_W   = ADDR_WIDTH - ADDR_LSB;
  localparam logic [WA_W-1:0] NUM_WA = WA_W'(NUM_REGS);

  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [WA_W-1:0]       wr_word, rd_word;
  logic                  ar_hs;

  axil_wr_join #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_join (
    .clk_i       (S_AXI_ACLK),
    .rst_n_i     (S_AXI_ARESETN),
    .awaddr_i    (S_AXI_AWADDR),
    .awvalid_i   (S_AXI_AWVALID),
    .awready_o   (S_AXI_AWREADY),
    .wdata_i     (S_AXI_WDATA),
    .wstrb_i     (S_AXI_WSTRB),
    .wvalid_i    (S_AXI_WVALID),
    .wready_o    (S_AXI_WREADY),
    .resp_busy_i (bvalid_q),
    .commit_o    (wr_commit),
    .addr_o      (wr_addr),
    .data_o      (wr_data),
    .strb_o      (wr_strb)
  );

  // Decode the whole word address so high offsets never alias onto a register.
  assign wr_word = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_word = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_hs   = S_AXI_ARVALID && !rvalid_q;

`ifdef AXIL_REG_SLAVE_WSTRB_EN
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, wr_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`else
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, wr_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0], wr_strb};
`endif

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_commit && wr_word == WA_W'(i)) begin
`ifdef AXIL_REG_SLAVE_WSTRB_EN
        regs_d[i] = strb_merge(regs_q[i], wr_data, wr_strb);
`else
        regs_d[i] = wr_data;
`endif
        pulse_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_word < NUM_WA) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      if (rd_word < NUM_WA) begin
        rresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rd_word == WA_W'(i)) rdata_d = regs_q[i];
        end
      end else if (rd_word == NUM_WA) begin
        rresp_d = RESP_OKAY;
        rdata_d = status_i;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      pulse_q  <= pulse_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_o[32*gi +: 32] = regs_q[gi];
    end
  endgenerate

  assign wr_pulse_o    = pulse_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed scenarios plus a randomized
// transaction mix checked against a word-addressed register model.
module tb_axil_reg_slave;

  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   awaddr, wdata, araddr, rdata, status;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic [32*NR-1:0] regs;
  logic [NR-1:0] pulse;

  int tests_run = 0;
  int fails = 0;
  logic [31:0] mdl [NR];

  axil_reg_slave #(.NUM_REGS(NR), .ADDR_WIDTH(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs), .wr_pulse_o(pulse), .status_i(status)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [32*NR-1:0] model_vec();
    logic [32*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = mdl[i];
    return v;
  endfunction

  // Model of a committed write: returns expected response and pulse.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] exp_resp, output logic [NR-1:0] exp_pulse);
    int unsigned w;
    w = addr >> 2;
    exp_pulse = '0;
    if (w < NR) begin
`ifdef AXIL_REG_SLAVE_WSTRB_EN
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[w][8*b +: 8] = data[8*b +: 8];
`else
      mdl[w] = data;
`endif
      exp_pulse[w] = 1'b1;
      exp_resp = 2'b00;
    end else begin
      exp_resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [31:0] st,
                            output logic [31:0] exp_data, output logic [1:0] exp_resp);
    int unsigned w;
    w = addr >> 2;
    if (w < NR) begin exp_data = mdl[w]; exp_resp = 2'b00; end
    else if (w == NR) begin exp_data = st; exp_resp = 2'b00; end
    else begin exp_data = '0; exp_resp = 2'b10; end
  endtask

  // Simultaneous AW+W one-cycle pulse with BREADY=1; returns at the negedge where BVALID is seen.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [NR-1:0] pl, output logic ok);
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0; resp = 2'bxx; pl = pulse;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bvalid) begin ok = 1'b1; resp = bresp; end
      else @(negedge clk);
    end
    $display("[TB] WR addr=%h data=%h strb=%b resp=%b pulse=%b", addr, data, strb, resp, pl);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output logic ok);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    ok = 1'b0; data = 'x; resp = 2'bxx;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rvalid) begin ok = 1'b1; data = rdata; resp = rresp; end
      else @(negedge clk);
    end
    $display("[TB] RD addr=%h data=%h resp=%b", addr, data, resp);
  endtask

  task automatic test_reset;
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++; $display("FAIL reset_ready: got %b want 111", {awready, wready, arready});
    end
    tests_run++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
      fails++; $display("FAIL reset_valid_resp: got %b want 000000", {bvalid, rvalid, bresp, rresp});
    end
    tests_run++;
    if (regs !== '0 || pulse !== '0 || rdata !== '0) begin
      fails++; $display("FAIL reset_regs: regs=%h pulse=%b rdata=%h want 0", regs, pulse, rdata);
    end
  endtask

  task automatic test_simultaneous;
    logic [1:0] r; logic [NR-1:0] p; logic ok;
    logic [1:0] er; logic [NR-1:0] ep;
    axi_write(32'h04, 32'h12345678, 4'hF, r, p, ok);
    model_write(32'h04, 32'h12345678, 4'hF, er, ep);
    tests_run++;
    if (!ok || r !== 2'b00) begin fails++; $display("FAIL simul_bresp: got %b ok=%b want 00", r, ok); end
    tests_run++;
    if (p !== 8'h02) begin fails++; $display("FAIL simul_pulse: got %h want 02", p); end
    tests_run++;
    if (regs[63:32] !== 32'h12345678) begin fails++; $display("FAIL simul_reg1: got %h want 12345678", regs[63:32]); end
    @(negedge clk);
    tests_run++;
    if (pulse !== '0 || bvalid !== 1'b0) begin
      fails++; $display("FAIL simul_pulse_once: pulse=%b bvalid=%b want 0", pulse, bvalid);
    end
  endtask

  task automatic test_split;
    logic [1:0] er; logic [NR-1:0] ep;
    @(negedge clk);
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
        fails++; $display("FAIL split_hold[%0d]: wready=%b awready=%b bvalid=%b want 0 1 0", i, wready, awready, bvalid);
      end
      if (i < 2) @(negedge clk);
    end
    awaddr = 32'h1C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    model_write(32'h1C, 32'hA5A5A5A5, 4'hF, er, ep);
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || pulse !== 8'h80) begin
      fails++; $display("FAIL split_commit: bvalid=%b bresp=%b pulse=%h want 1 00 80", bvalid, bresp, pulse);
    end
    tests_run++;
    if (regs[255:224] !== 32'hA5A5A5A5) begin fails++; $display("FAIL split_reg7: got %h want a5a5a5a5", regs[255:224]); end
    $display("[TB] WR split addr=0000001c data=a5a5a5a5");
  endtask

  task automatic test_out_of_range;
    logic [1:0] r; logic [NR-1:0] p; logic ok; logic [31:0] d;
    logic [31:0] addrs [2];
    addrs[0] = 32'h20; addrs[1] = 32'h40;
    for (int i = 0; i < 2; i++) begin
      axi_write(addrs[i], 32'hCAFEF00D, 4'hF, r, p, ok);
      tests_run++;
      if (!ok || r !== 2'b10 || p !== '0 || regs !== model_vec()) begin
        fails++; $display("FAIL oor_write_%h: resp=%b pulse=%b ok=%b regs=%h want 10 0 model=%h",
                          addrs[i], r, p, ok, regs, model_vec());
      end
    end
    status = 32'hDEADBEEF;
    axi_read(32'h20, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
      fails++; $display("FAIL status_read: data=%h resp=%b want deadbeef 00", d, r);
    end
    axi_read(32'h40, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin
      fails++; $display("FAIL oor_read: data=%h resp=%b want 0 10", d, r);
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] er; logic [NR-1:0] ep; logic [31:0] s1, v;
    v = $urandom;
    @(negedge clk);
    awaddr = 32'h08; wdata = v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(32'h08, v, 4'hF, er, ep);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        fails++; $display("FAIL bp_write[%0d]: bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                          i, bvalid, bresp, awready, wready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || regs !== model_vec()) begin
      fails++; $display("FAIL bp_release: bvalid=%b awready=%b wready=%b want 0 1 1", bvalid, awready, wready);
    end
    s1 = $urandom;
    status = s1; araddr = 32'h20; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0; status = ~s1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (rvalid !== 1'b1 || rdata !== s1 || rresp !== 2'b00 || arready !== 1'b0) begin
        fails++; $display("FAIL bp_read[%0d]: rvalid=%b rdata=%h arready=%b want 1 %h 0", i, rvalid, rdata, arready, s1);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      fails++; $display("FAIL bp_read_release: rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] r, er; logic [NR-1:0] p, ep; logic ok;
    logic [31:0] want;
`ifdef AXIL_REG_SLAVE_WSTRB_EN
    want = 32'hFF00FF00;
`else
    want = 32'h00000000;
`endif
    axi_write(32'h08, 32'hFFFFFFFF, 4'hF, r, p, ok);
    model_write(32'h08, 32'hFFFFFFFF, 4'hF, er, ep);
    axi_write(32'h08, 32'h00000000, 4'b0101, r, p, ok);
    model_write(32'h08, 32'h00000000, 4'b0101, er, ep);
    tests_run++;
    if (regs[95:64] !== want || p !== 8'h04) begin
      fails++; $display("FAIL strobe_reg2: got %h pulse=%h want %h 04", regs[95:64], p, want);
    end
    axi_write(32'h08, 32'h12345678, 4'b0000, r, p, ok);
    model_write(32'h08, 32'h12345678, 4'b0000, er, ep);
    tests_run++;
    if (p !== 8'h04 || regs !== model_vec()) begin
      fails++; $display("FAIL strobe_zero: pulse=%h reg2=%h want 04 %h", p, regs[95:64], mdl[2]);
    end
  endtask

  task automatic test_same_edge;
    logic [31:0] old_v, new_v; logic [1:0] er; logic [NR-1:0] ep;
    old_v = mdl[4]; new_v = ~old_v ^ 32'h0F0F0001;
    @(negedge clk);
    awaddr = 32'h10; wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(32'h10, new_v, 4'hF, er, ep);
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== old_v) begin
      fails++; $display("FAIL same_edge_read: rvalid=%b rdata=%h want 1 %h", rvalid, rdata, old_v);
    end
    tests_run++;
    if (bvalid !== 1'b1 || regs[159:128] !== new_v) begin
      fails++; $display("FAIL same_edge_write: bvalid=%b reg4=%h want 1 %h", bvalid, regs[159:128], new_v);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d; logic [1:0] er; logic [NR-1:0] ep;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a = 32'(k) << 2; d = $urandom;
      tests_run++;
      if (awready !== 1'b1 || wready !== 1'b1) begin
        fails++; $display("FAIL b2b_ready[%0d]: awready=%b wready=%b want 1 1", k, awready, wready);
      end
      awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(a, d, 4'hF, er, ep);
      tests_run++;
      if (bvalid !== 1'b1 || pulse !== ep || regs !== model_vec()) begin
        fails++; $display("FAIL b2b_commit[%0d]: bvalid=%b pulse=%b want 1 %b", k, bvalid, pulse, ep);
      end
      $display("[TB] WR b2b addr=%h data=%h", a, d);
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d, st, got, ed; logic [3:0] s;
    logic [1:0] r, er; logic [NR-1:0] p, ep; logic ok;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, r, p, ok);
        model_write(a, d, s, er, ep);
        tests_run++;
        if (!ok || r !== er || p !== ep || regs !== model_vec()) begin
          fails++; $display("FAIL rand_write[%0d] addr=%h: resp=%b pulse=%b ok=%b want %b %b", n, a, r, p, ok, er, ep);
        end
      end else begin
        st = $urandom; status = st;
        axi_read(a, got, r, ok);
        model_read(a, st, ed, er);
        tests_run++;
        if (!ok || got !== ed || r !== er) begin
          fails++; $display("FAIL rand_read[%0d] addr=%h: data=%h resp=%b want %h %b", n, a, got, r, ed, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    awaddr = 32'h0C; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 32'h00; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      fails++; $display("FAIL rstmid_pending: bvalid=%b rvalid=%b want 1 1", bvalid, rvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_0_0_00_00 ||
        regs !== '0 || pulse !== '0 || rdata !== '0) begin
      fails++; $display("FAIL rstmid_outputs: rdy=%b bv=%b rv=%b regs=%h pulse=%b rdata=%h want reset values",
                        {awready, wready, arready}, bvalid, rvalid, regs, pulse, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
        fails++; $display("FAIL rstmid_stale[%0d]: bvalid=%b rvalid=%b want 0 0", i, bvalid, rvalid);
      end
    end
    awaddr = 32'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    tests_run++;
    if (awready !== 1'b0) begin fails++; $display("FAIL rstmid_aw_held: awready=%b want 0", awready); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (awready !== 1'b1) begin fails++; $display("FAIL rstmid_aw_drop: awready=%b want 1", awready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wdata = 32'h22222222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0 || wready !== 1'b0) begin
      fails++; $display("FAIL rstmid_no_join: bvalid=%b wready=%b want 0 0", bvalid, wready);
    end
    awaddr = 32'h14; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    mdl[5] = 32'h22222222;
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || regs !== model_vec()) begin
      fails++; $display("FAIL rstmid_rejoin: bvalid=%b bresp=%b regs=%h want 1 00 %h", bvalid, bresp, regs, model_vec());
    end
    $display("[TB] WR after reset addr=00000014 data=22222222");
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1; status = '0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_simultaneous();
    test_split();
    test_out_of_range();
    test_backpressure();
    test_strobe();
    test_same_edge();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
